pixel_write_fifo: RTL and testbench

- Receives completed pixel pairs from the Z-compare stage (write_enqueue / write_* bundle) and buffers them.
- Drains the buffer onto the SDRAM Avalon-MM write port: one color write per entry, plus one Z write per entry when Z is active.
- Per-pixel byteenables come from pixel_active, so masked pixels never modify memory.
- Sits between the Z-compare stage and the memory arbiter's write master.

---
 rtl/pixel_write_fifo.sv | 188 ++++++++++++++++++
 tb/tb_pixel_write_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_fifo.sv
// Buffers Z-compare pixel pairs and drains them as Avalon-MM color (and optional Z) writes.
// Latency: enqueue into an idle, empty FIFO shows write_write one edge later; outputs hold under write_waitrequest.
module pixel_write_fifo_buf #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_dat_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_dat_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o
);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_ok, pop_ok;

  assign full_o     = (count_q == CNT_MAX);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module pixel_write_fifo #(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       z_active,
  input  logic                       enqueue,
  input  logic [28:0]                color_address,
  input  logic [63:0]                color,
  input  logic [28:0]                z_address,
  input  logic [63:0]                z,
  input  logic [1:0]                 pixel_active,
  output logic [FIFO_DEPTH_LOG2:0]   size,
  output logic                       overflow,
  output logic                       busy,
  output logic [28:0]                write_address,
  output logic [63:0]                write_writedata,
  output logic [7:0]                 write_byteenable,
  output logic                       write_write,
  input  logic                       write_waitrequest
);
  typedef struct packed {
    logic [1:0]  pa;
    logic [63:0] z;
    logic [28:0] za;
    logic [63:0] color;
    logic [28:0] ca;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_COLOR, S_Z} state_t;

  entry_t                   in_ent, head;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic                     full, pop, accept, load_next;

  state_t      state_q, state_d;
  logic [28:0] addr_q, addr_d, za_q, za_d;
  logic [63:0] data_q, data_d, z_q, z_d;
  logic [7:0]  be_q, be_d;
  logic        wr_q, wr_d, zact_q, zact_d, ovf_q, ovf_d;

  assign in_ent = '{pa: pixel_active, z: z, za: z_address, color: color, ca: color_address};

  pixel_write_fifo_buf #(
    .WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_buf (
    .clock(clock), .reset_n(reset_n),
    .push_i(enqueue), .push_dat_i(in_ent),
    .pop_i(pop), .head_dat_o(head),
    .count_o(count), .full_o(full)
  );

  assign accept = wr_q & ~write_waitrequest;
  // A drop is reported even when a pop frees a slot in the same cycle.
  assign ovf_d  = ovf_q | (enqueue & full);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    wr_d      = wr_q;
    zact_d    = zact_q;
    za_d      = za_q;
    z_d       = z_q;
    pop       = 1'b0;
    load_next = 1'b0;
    case (state_q)
      S_IDLE:  load_next = (count != '0);
      S_COLOR: begin
        if (accept) begin
          if (zact_q) begin
            state_d = S_Z;
            addr_d  = za_q;
            data_d  = z_q;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      S_Z:     load_next = accept;
      default: state_d = S_IDLE;
    endcase
    // Pop the head straight into the output registers so drains run with no bubble.
    if (load_next) begin
      state_d = S_IDLE;
      wr_d    = 1'b0;
      if (count != '0) begin
        pop = 1'b1;
        if (head.pa != 2'b00) begin
          state_d = S_COLOR;
          wr_d    = 1'b1;
          addr_d  = head.ca;
          data_d  = head.color;
          be_d    = {{4{head.pa[1]}}, {4{head.pa[0]}}};
          zact_d  = z_active;
          za_d    = head.za;
          z_d     = head.z;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      zact_q  <= 1'b0;
      za_q    <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      zact_q  <= zact_d;
      za_q    <= za_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
    end
  end

  assign size             = count;
  assign overflow         = ovf_q;
  assign busy             = (count != '0) | (state_q != S_IDLE);
  assign write_address    = addr_q;
  assign write_writedata  = data_q;
  assign write_byteenable = be_q;
  assign write_write      = wr_q;
endmodule

// File: tb/tb_pixel_write_fifo.sv
// Directed bench for pixel_write_fifo: latency, Z pairing, waitrequest hold, overflow, drain order, reset.
module tb_pixel_write_fifo;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        z_active = 1'b0;
  logic        enqueue = 1'b0;
  logic [28:0] color_address = '0;
  logic [63:0] color = '0;
  logic [28:0] z_address = '0;
  logic [63:0] z = '0;
  logic [1:0]  pixel_active = '0;
  logic [5:0]  size;
  logic        overflow, busy;
  logic [28:0] write_address;
  logic [63:0] write_writedata;
  logic [7:0]  write_byteenable;
  logic        write_write;
  logic        write_waitrequest = 1'b0;

  int errors = 0;
  int checks = 0;

  pixel_write_fifo dut (
    .clock(clock), .reset_n(reset_n), .z_active(z_active), .enqueue(enqueue),
    .color_address(color_address), .color(color), .z_address(z_address), .z(z),
    .pixel_active(pixel_active), .size(size), .overflow(overflow), .busy(busy),
    .write_address(write_address), .write_writedata(write_writedata),
    .write_byteenable(write_byteenable), .write_write(write_write),
    .write_waitrequest(write_waitrequest)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input logic [28:0] ca, input logic [63:0] c,
                           input logic [28:0] za, input logic [63:0] zz, input logic [1:0] pa);
    color_address = ca; color = c; z_address = za; z = zz; pixel_active = pa;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, first, last, cyc;
    logic [28:0] seen;

    // Reset
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_size", size, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_write", write_write, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", write_writedata, 0);
    chk("rst_be", write_byteenable, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // Single entry, Z off
    z_active = 1'b0;
    set_entry(29'h100, 64'h11112222_33334444, 29'h0, 64'h0, 2'b11);
    enqueue = 1'b1;
    tick();
    enqueue = 1'b0;
    chk("t1_write_early", write_write, 0);
    chk("t1_size1", size, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_write", write_write, 1);
    chk("t1_addr", write_address, 29'h100);
    chk("t1_data", write_writedata, 64'h11112222_33334444);
    chk("t1_be", write_byteenable, 8'hFF);
    chk("t1_size0", size, 0);
    tick();
    chk("t1_write_done", write_write, 0);
    chk("t1_busy_done", busy, 0);

    // Z on, right pixel only
    z_active = 1'b1;
    set_entry(29'h200, 64'hAAAA0000_BBBB0000, 29'h800, 64'hCCCC1111_DDDD2222, 2'b10);
    enqueue = 1'b1;
    tick();
    enqueue = 1'b0;
    tick();
    chk("t2_c_write", write_write, 1);
    chk("t2_c_addr", write_address, 29'h200);
    chk("t2_c_data", write_writedata, 64'hAAAA0000_BBBB0000);
    chk("t2_c_be", write_byteenable, 8'hF0);
    tick();
    chk("t2_z_write", write_write, 1);
    chk("t2_z_addr", write_address, 29'h800);
    chk("t2_z_data", write_writedata, 64'hCCCC1111_DDDD2222);
    chk("t2_z_be", write_byteenable, 8'hF0);
    tick();
    chk("t2_done", write_write, 0);
    chk("t2_busy", busy, 0);

    // Waitrequest stall on the color write
    write_waitrequest = 1'b1;
    set_entry(29'h300, 64'h01234567_89ABCDEF, 29'h900, 64'hFEDCBA98_76543210, 2'b01);
    enqueue = 1'b1;
    tick();
    enqueue = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_write", write_write, 1);
      chk("t3_hold_addr", write_address, 29'h300);
      chk("t3_hold_data", write_writedata, 64'h01234567_89ABCDEF);
      chk("t3_hold_be", write_byteenable, 8'h0F);
      tick();
    end
    write_waitrequest = 1'b0;
    chk("t3_pre_accept", write_address, 29'h300);
    tick();
    chk("t3_z_write", write_write, 1);
    chk("t3_z_addr", write_address, 29'h900);
    chk("t3_z_data", write_writedata, 64'hFEDCBA98_76543210);
    chk("t3_z_be", write_byteenable, 8'h0F);
    tick();
    chk("t3_done", write_write, 0);

    // Overflow: one in flight, 32 buffered, one dropped
    z_active = 1'b0;
    write_waitrequest = 1'b1;
    for (int i = 0; i < 34; i++) begin
      set_entry(29'h1000 + 29'(i), 64'(i), 29'h0, 64'h0, 2'b11);
      enqueue = 1'b1;
      tick();
    end
    enqueue = 1'b0;
    chk("t4_size_full", size, 32);
    chk("t4_overflow", overflow, 1);
    chk("t4_inflight_addr", write_address, 29'h1000);
    write_waitrequest = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 33 && cyc < 80) begin
      if (write_write) begin
        chk("t4_order_addr", write_address, 29'h1000 + 29'(n));
        n++;
      end
      tick();
      cyc++;
    end
    chk("t4_write_count", n, 33);
    chk("t4_cycles", cyc, 33);
    chk("t4_no_extra", write_write, 0);
    chk("t4_size_empty", size, 0);

    // Back-to-back, Z off
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        set_entry(29'h40 + 29'(c), 64'h0, 29'h0, 64'h0, 2'b11);
        enqueue = 1'b1;
      end else begin
        enqueue = 1'b0;
      end
      tick();
      if (write_write) begin
        chk("t5_addr", write_address, 29'h40 + 29'(n));
        if (n == 0) first = c;
        last = c;
        n++;
      end
    end
    chk("t5_count", n, 4);
    chk("t5_consecutive", last - first, 3);

    // Fully masked entry produces no write
    n = 0; seen = '0;
    for (int c = 0; c < 6; c++) begin
      enqueue = (c < 2);
      set_entry((c == 0) ? 29'h50 : 29'h51, 64'h0, 29'h0, 64'h0, (c == 0) ? 2'b00 : 2'b11);
      tick();
      if (write_write) begin
        seen = write_address;
        chk("t5b_be", write_byteenable, 8'hFF);
        n++;
      end
    end
    enqueue = 1'b0;
    chk("t5b_count", n, 1);
    chk("t5b_addr", seen, 29'h51);

    // Reset during a Z write with three entries buffered
    z_active = 1'b1;
    write_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_entry(29'h60 + 29'(i), 64'h0, 29'hA0 + 29'(i), 64'h0, 2'b11);
      enqueue = 1'b1;
      tick();
    end
    enqueue = 1'b0;
    write_waitrequest = 1'b0;
    tick();
    write_waitrequest = 1'b1;
    chk("t6_z_addr", write_address, 29'hA0);
    chk("t6_size3", size, 3);
    reset_n = 1'b0;
    #1;
    chk("t6_write_now", write_write, 0);
    chk("t6_size_now", size, 0);
    chk("t6_overflow", overflow, 0);
    tick();
    reset_n = 1'b1;
    write_waitrequest = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (write_write) n++;
    end
    chk("t6_no_writes", n, 0);
    chk("t6_size_after", size, 0);
    chk("t6_busy_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
